// File: rtl/fetch_stage.sv
// Purpose: two-stage instruction fetch (PC + synchronous imem slot) feeding a registered IF/ID.
// Latency: the instruction at PC A appears on IF/ID two edges after A enters pc_q.
// Backpressure: stall freezes PC, the in-flight slot and IF/ID; redirect overrides stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q;
    logic        f1_valid;
    logic [31:0] f1_pc;

    // Targets are word aligned, so the low two bits of redirect_pc are dropped.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The memory is addressed straight from pc_q; it must also read on a redirect
    // so that its output register is refilled even while decode is stalled.
    assign imem_addr = pc_q;
    assign imem_en   = (~stall) | redirect;

    // PC, in-flight slot and IF/ID register; priority is reset, redirect, stall, advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            f1_valid       <= 1'b0;
            f1_pc          <= 32'h0000_0000;
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= 32'h0000_0000;
            if_id_pc_plus4 <= 32'h0000_0004;
            fetch_count    <= 32'h0000_0000;
        end else if (redirect) begin
            // Flush both the in-flight slot and IF/ID; if_id_pc keeps its value
            // so if_id_pc_plus4 stays consistent with it.
            pc_q        <= {redirect_pc[31:2], 2'b00};
            f1_valid    <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (!stall) begin
            pc_q     <= pc_q + 32'd4;
            f1_valid <= 1'b1;
            f1_pc    <= pc_q;
            if (f1_valid) begin
                if_id_instr    <= imem_rdata;
                if_id_pc       <= f1_pc;
                if_id_pc_plus4 <= f1_pc + 32'd4;
                if_id_valid    <= 1'b1;
                fetch_count    <= fetch_count + 32'd1;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, redirect, redirect+stall,
// PC wrap (second instance with a high RESET_PC) and reset during a stall.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    // ---------------- DUT 1: default RESET_PC ----------------
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        imem_en, if_id_valid;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    // ---------------- DUT 2: RESET_PC near the top of memory ----------------
    logic        reset2 = 1'b1;
    logic        stall2 = 1'b0, redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] imem_addr2, imem_rdata2, if_id_instr2, if_id_pc2, if_id_pc_plus42, fetch_count2;
    logic        imem_en2, if_id_valid2;

    fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut2 (
        .clock(clock), .reset(reset2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_en(imem_en2),
        .imem_rdata(imem_rdata2), .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2),
        .if_id_pc_plus4(if_id_pc_plus42), .if_id_valid(if_id_valid2), .fetch_count(fetch_count2)
    );

    // Memory contents: word[i] = 0x1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Synchronous instruction memories with enable-qualified output registers.
    always @(posedge clock) if (imem_en)  imem_rdata  <= mem_word(imem_addr);
    always @(posedge clock) if (imem_en2) imem_rdata2 <= mem_word(imem_addr2);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset DUT 1 for one edge, then run n further normal edges.
    task automatic reset_and_run(input int n);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count, imem_addr} !==
            {1'b0, NOP, 32'h0, 32'h4, 32'h0, 32'h0}) begin
            $display("FAIL reset_state: got v=%b i=%h pc=%h p4=%h cnt=%h a=%h, expected 0 %h 0 4 0 0",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count, imem_addr, NOP);
        end else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        reset = 1'b0;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_instr, fetch_count, imem_addr} !== {1'b0, NOP, 32'h0, 32'h4}) begin
            $display("FAIL first_edge_bubble: got v=%b i=%h cnt=%h a=%h, expected 0 %h 0 4",
                     if_id_valid, if_id_instr, fetch_count, imem_addr, NOP);
        end else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            exp_pc = 32'(4 * k);
            total_cnt++;
            if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count} !==
                {1'b1, exp_pc, exp_pc + 32'd4, 32'h1000_0000 + 32'(k), 32'(k + 1)}) begin
                $display("FAIL stream_%0d: got v=%b pc=%h p4=%h i=%h cnt=%0d, expected 1 %h %h %h %0d",
                         k, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count,
                         exp_pc, exp_pc + 32'd4, 32'h1000_0000 + 32'(k), k + 1);
            end else pass_cnt++;
        end
    endtask

    // Entered with if_id_pc = 8 and fetch_count = 3.
    task automatic test_stall();
        stall = 1'b1;
        #1;
        total_cnt++;
        if (imem_en !== 1'b0) begin
            $display("FAIL stall_imem_en: got %b expected 0", imem_en);
        end else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if ({if_id_valid, if_id_pc, if_id_instr, fetch_count, imem_addr} !==
                {1'b1, 32'h8, 32'h1000_0002, 32'd3, 32'h10}) begin
                $display("FAIL stall_hold_%0d: got v=%b pc=%h i=%h cnt=%0d a=%h, expected 1 8 10000002 3 10",
                         k, if_id_valid, if_id_pc, if_id_instr, fetch_count, imem_addr);
            end else pass_cnt++;
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            total_cnt++;
            if ({if_id_valid, if_id_pc, if_id_instr, fetch_count} !==
                {1'b1, 32'(12 + 4 * k), 32'h1000_0003 + 32'(k), 32'(4 + k)}) begin
                $display("FAIL stall_release_%0d: got v=%b pc=%h i=%h cnt=%0d, expected 1 %h %h %0d",
                         k, if_id_valid, if_id_pc, if_id_instr, fetch_count,
                         32'(12 + 4 * k), 32'h1000_0003 + 32'(k), 4 + k);
            end else pass_cnt++;
        end
    endtask

    // Shared flush-and-refill sequence; 'with_stall' holds stall=1 on the redirect edge.
    task automatic test_redirect(input bit with_stall, input logic [31:0] target);
        reset_and_run(4);
        total_cnt++;
        if ({if_id_valid, if_id_pc, fetch_count} !== {1'b1, 32'h8, 32'd3}) begin
            $display("FAIL redir_setup_%0d: got v=%b pc=%h cnt=%0d, expected 1 8 3",
                     with_stall, if_id_valid, if_id_pc, fetch_count);
        end else pass_cnt++;
        redirect = 1'b1; redirect_pc = target; stall = with_stall;
        #1;
        total_cnt++;
        if (imem_en !== 1'b1) begin
            $display("FAIL redir_imem_en_%0d: got %b expected 1", with_stall, imem_en);
        end else pass_cnt++;
        step();
        redirect = 1'b0; stall = 1'b0;
        total_cnt++;
        if ({if_id_valid, if_id_instr, fetch_count, imem_addr} !== {1'b0, NOP, 32'd3, 32'h40}) begin
            $display("FAIL redir_flush_%0d: got v=%b i=%h cnt=%0d a=%h, expected 0 %h 3 40",
                     with_stall, if_id_valid, if_id_instr, fetch_count, imem_addr, NOP);
        end else pass_cnt++;
        total_cnt++;
        if (if_id_pc_plus4 !== if_id_pc + 32'd4) begin
            $display("FAIL redir_plus4_%0d: got %h expected %h", with_stall, if_id_pc_plus4, if_id_pc + 32'd4);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_instr, fetch_count} !== {1'b0, NOP, 32'd3}) begin
            $display("FAIL redir_bubble2_%0d: got v=%b i=%h cnt=%0d, expected 0 %h 3",
                     with_stall, if_id_valid, if_id_instr, fetch_count, NOP);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count} !==
            {1'b1, 32'h40, 32'h44, 32'h1000_0010, 32'd4}) begin
            $display("FAIL redir_target_%0d: got v=%b pc=%h p4=%h i=%h cnt=%0d, expected 1 40 44 10000010 4",
                     with_stall, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count);
        end else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        reset2 = 1'b1;
        step();
        total_cnt++;
        if (imem_addr2 !== WRAP_PC) begin
            $display("FAIL wrap_reset_addr: got %h expected %h", imem_addr2, WRAP_PC);
        end else pass_cnt++;
        reset2 = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if ({if_id_valid2, if_id_pc2, if_id_pc_plus42, if_id_instr2} !==
                {1'b1, exp_pc[k], exp_pc[k] + 32'd4, mem_word(exp_pc[k])}) begin
                $display("FAIL wrap_%0d: got v=%b pc=%h p4=%h i=%h, expected 1 %h %h %h",
                         k, if_id_valid2, if_id_pc2, if_id_pc_plus42, if_id_instr2,
                         exp_pc[k], exp_pc[k] + 32'd4, mem_word(exp_pc[k]));
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_stall();
        reset_and_run(4);
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count, imem_addr} !==
            {1'b0, NOP, 32'h0, 32'h4, 32'h0, 32'h0}) begin
            $display("FAIL reset_mid_stall: got v=%b i=%h pc=%h p4=%h cnt=%h a=%h, expected 0 %h 0 4 0 0",
                     if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count, imem_addr, NOP);
        end else pass_cnt++;
        reset = 1'b0; stall = 1'b0;
        step();
        total_cnt++;
        if ({if_id_valid, fetch_count} !== {1'b0, 32'h0}) begin
            $display("FAIL reset_discard: got v=%b cnt=%0d, expected 0 0", if_id_valid, fetch_count);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({if_id_valid, if_id_pc, if_id_instr, fetch_count} !== {1'b1, 32'h0, 32'h1000_0000, 32'd1}) begin
            $display("FAIL reset_restart: got v=%b pc=%h i=%h cnt=%0d, expected 1 0 10000000 1",
                     if_id_valid, if_id_pc, if_id_instr, fetch_count);
        end else pass_cnt++;
    endtask

    initial begin
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_redirect(1'b0, 32'h0000_0040);
        test_redirect(1'b1, 32'h0000_0043);
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
